// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduler: FSM state encoding, default byte
// width and a constant-evaluable clog2 helper.
package uart_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_HDR  = 2'd2,
        ST_DATA = 2'd3
    } sched_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((1 << i) < n) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly after
// ptr, wrapping from N-1 back to 0 (ptr itself is checked last).
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] id
);

    logic          w_found;
    logic          w_take;
    logic [IW-1:0] w_idx;

    // Walk the requests in rotated order; the first hit wins and later hits are masked.
    always_comb begin
        w_found = 1'b0;
        w_take  = 1'b0;
        w_idx   = '0;
        id      = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx   = IW'((int'(ptr) + k) % N);
            w_take  = req[w_idx] & ~w_found;
            id      = w_take ? w_idx : id;
            w_found = w_found | req[w_idx];
        end
        any = w_found;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one TX_SEND serializer among NREQ byte producers,
// optionally prefixing each burst with a header byte that carries the requester id.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int             NREQ      = 4,
    parameter int             DW        = DW_DEFAULT,
    parameter bit             HDR_EN    = 1'b1,
    parameter logic [DW-1:0]  HDR_BASE  = 8'hF0,
    parameter int             BURST_MAX = 16,
    parameter int             GAP_MAX   = 64
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 tx_rdy,
    output logic                 tx_wen,
    output logic [DW-1:0]        tx_din,
    output logic [NREQ-1:0]      grant,
    output logic                 busy
);

    localparam int IDW = (NREQ > 1) ? clog2(NREQ) : 1;

    sched_state_e    r_state;
    sched_state_e    w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW-1:0]  r_id;
    logic [IDW-1:0]  w_id_nxt;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] w_grant_nxt;
    logic [7:0]      r_bcnt;
    logic [7:0]      w_bcnt_nxt;
    logic [7:0]      r_gap;
    logic [7:0]      w_gap_nxt;
    logic            r_armed;

    logic            w_any;
    logic [IDW-1:0]  w_pick;
    logic            w_fire;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic            w_wen;
    logic [DW-1:0]   w_din;
    logic [NREQ-1:0] w_ready;

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_any),
        .id  (w_pick)
    );

    // armed guarantees a single write per TX_SEND frame even when rdy falls late
    assign w_fire      = r_armed & tx_rdy;
    assign w_sel_valid = req_valid[r_id];
    assign w_sel_last  = req_last[r_id];
    assign w_sel_data  = req_data[int'(r_id)*DW +: DW];

    // Next-state, counter updates and the zero-latency handshake toward TX_SEND.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_id_nxt    = r_id;
        w_grant_nxt = r_grant;
        w_bcnt_nxt  = r_bcnt;
        w_gap_nxt   = r_gap;
        w_wen       = 1'b0;
        w_din       = '0;
        w_ready     = '0;
        case (r_state)
            ST_IDLE: begin
                if (|req_valid) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (w_any) begin
                    w_id_nxt    = w_pick;
                    w_ptr_nxt   = w_pick;
                    w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                    w_bcnt_nxt  = 8'd0;
                    w_gap_nxt   = 8'd0;
                    w_state_nxt = HDR_EN ? ST_HDR : ST_DATA;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (w_fire) begin
                    w_wen       = 1'b1;
                    w_din       = HDR_BASE | DW'(r_id);
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_DATA: begin
                w_ready[r_id] = w_fire;
                if (w_sel_valid && w_fire) begin
                    w_wen      = 1'b1;
                    w_din      = w_sel_data;
                    w_bcnt_nxt = r_bcnt + 8'd1;
                    w_gap_nxt  = 8'd0;
                    if (w_sel_last || (w_bcnt_nxt == 8'(BURST_MAX))) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_bcnt_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else if (!w_sel_valid) begin
                    w_gap_nxt = r_gap + 8'd1;
                    if (w_gap_nxt == 8'(GAP_MAX)) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_bcnt_nxt  = 8'd0;
                        w_gap_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // FSM, arbitration pointer, owner and burst/gap counters.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state <= ST_IDLE;
            r_ptr   <= IDW'(NREQ - 1);
            r_id    <= '0;
            r_grant <= '0;
            r_bcnt  <= 8'd0;
            r_gap   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_id_nxt;
            r_grant <= w_grant_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Disarm on every write, re-arm once TX_SEND has been seen busy.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_armed <= 1'b1;
        end else if (w_wen) begin
            r_armed <= 1'b0;
        end else if (!tx_rdy) begin
            r_armed <= 1'b1;
        end else begin
            r_armed <= r_armed;
        end
    end

    assign tx_wen    = w_wen;
    assign tx_din    = w_din;
    assign req_ready = w_ready;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);

endmodule
